// File: rtl/mem_port_pkg.sv
// Shared constants and helpers for the memory-port arbiter.
// Load/store codes, access-size codes and the index-width helper.
package mem_port_pkg;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    localparam int MT_W = 3;
    localparam logic [MT_W-1:0] MT_X  = 3'd0;
    localparam logic [MT_W-1:0] MT_B  = 3'd1;
    localparam logic [MT_W-1:0] MT_H  = 3'd2;
    localparam logic [MT_W-1:0] MT_WD = 3'd3;
    localparam logic [MT_W-1:0] MT_BU = 3'd4;
    localparam logic [MT_W-1:0] MT_HU = 3'd5;

    // Width of an index into n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Client-side and memory-side request/response bundle of mem_port_arb.
// slave: arbiter view; master: the clients plus memory around it.
interface mem_port_arb_if
    import mem_port_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic [NPORT-1:0]      cl_req_valid;
    logic [NPORT-1:0]      cl_req_ready;
    logic [NPORT*AW-1:0]   cl_req_addr;
    logic [NPORT*DW-1:0]   cl_req_data;
    logic [NPORT-1:0]      cl_req_fcn;
    logic [NPORT*MT_W-1:0] cl_req_typ;
    logic [NPORT-1:0]      cl_resp_valid;
    logic [DW-1:0]         cl_resp_data;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [AW-1:0]         mem_req_addr;
    logic [DW-1:0]         mem_req_data;
    logic                  mem_req_fcn;
    logic [MT_W-1:0]       mem_req_typ;
    logic                  mem_resp_valid;
    logic [DW-1:0]         mem_resp_data;

    modport slave (
        input  cl_req_valid, cl_req_addr, cl_req_data,
        input  cl_req_fcn, cl_req_typ,
        output cl_req_ready, cl_resp_valid, cl_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_data,
        output mem_req_fcn, mem_req_typ,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output cl_req_valid, cl_req_addr, cl_req_data,
        output cl_req_fcn, cl_req_typ,
        input  cl_req_ready, cl_resp_valid, cl_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_data,
        input  mem_req_fcn, mem_req_typ,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arb_idfifo.sv
// Synchronous FIFO holding the port index of each outstanding request.
// Push is ignored when full and pop when empty.
module mem_arb_idfifo
    import mem_port_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rptr_q];

    // DEPTH is a power of two, so pointers wrap by overflow.
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wptr_q] = din;
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mem_port_arb.sv
// Round-robin N-client arbiter onto one in-order memory port.
// Define MEM_ARB_PERF_EN for per-client grant counters (perf_grant_cnt).
module mem_port_arb
    import mem_port_pkg::*;
#(
    parameter int NPORT  = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int QDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_arb_if.slave  bus,
    output logic           err_orphan
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NPORT*32-1:0] perf_grant_cnt
`endif
);
    localparam int IW = idx_w(NPORT);
    typedef logic [IW-1:0] idx_t;

    idx_t             rr_ptr_q, rr_ptr_d;
    idx_t             gnt_idx;
    idx_t             head;
    logic [NPORT-1:0] grant;
    logic             found;
    int               rr_j;
    logic             fifo_full, fifo_empty;
    logic             hs, pop;
    logic             err_orphan_q, err_orphan_d;

    // First valid client at or after rr_ptr wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        rr_j    = 0;
        for (int k = 0; k < NPORT; k++) begin
            rr_j = (int'(rr_ptr_q) + k) % NPORT;
            if (!found && bus.cl_req_valid[rr_j]) begin
                found   = 1'b1;
                gnt_idx = idx_t'(rr_j);
            end
        end
        grant = found ? (NPORT'(1) << gnt_idx) : '0;
    end

    assign bus.mem_req_valid = (|bus.cl_req_valid) & ~fifo_full;
    assign bus.mem_req_addr  = bus.cl_req_addr[int'(gnt_idx)*AW +: AW];
    assign bus.mem_req_data  = bus.cl_req_data[int'(gnt_idx)*DW +: DW];
    assign bus.mem_req_fcn   = bus.cl_req_fcn[gnt_idx];
    assign bus.mem_req_typ   = bus.cl_req_typ[int'(gnt_idx)*MT_W +: MT_W];
    assign bus.cl_req_ready  =
        grant & {NPORT{bus.mem_req_ready & ~fifo_full}};

    assign hs  = bus.mem_req_valid & bus.mem_req_ready;
    assign pop = bus.mem_resp_valid & ~fifo_empty;

    assign bus.cl_resp_valid = pop ? (NPORT'(1) << head) : '0;
    assign bus.cl_resp_data  = bus.mem_resp_data;
    assign err_orphan        = err_orphan_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (int'(gnt_idx) == NPORT - 1) ? '0
                                                     : gnt_idx + idx_t'(1);
        end
        err_orphan_d = err_orphan_q | (bus.mem_resp_valid & fifo_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    mem_arb_idfifo #(
        .WIDTH (IW),
        .DEPTH (QDEPTH)
    ) u_idfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .din   (gnt_idx),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MEM_ARB_PERF_EN
    logic [NPORT*32-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < NPORT; i++) begin
            if (hs && grant[i]) perf_d[i*32 +: 32] = perf_q[i*32 +: 32] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) perf_q <= '0;
        else      perf_q <= perf_d;
    end

    assign perf_grant_cnt = perf_q;
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed vector bench for mem_port_arb (NPORT=2, QDEPTH=4).
// Table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_mem_port_arb;
    import mem_port_pkg::*;

    typedef struct {
        logic [1:0]  v;
        logic        mrdy;
        logic        rv;
        logic [31:0] rdata;
        logic [1:0]  crdy;
        logic        mval;
        logic [31:0] addr;
        logic [1:0]  crv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_orphan;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [15];
    int   gcnt [2];
`ifdef MEM_ARB_PERF_EN
    logic [63:0] perf_grant_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arb_if #(.NPORT(2), .AW(32), .DW(32)) bus ();

    mem_port_arb #(
        .NPORT(2), .AW(32), .DW(32), .QDEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .err_orphan (err_orphan)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic mrdy,
                         input logic rv, input logic [31:0] rd);
        bus.cl_req_valid   = v;
        bus.mem_req_ready  = mrdy;
        bus.mem_resp_valid = rv;
        bus.mem_resp_data  = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        bus.cl_req_addr = {32'h200, 32'h100};
        bus.cl_req_data = {32'h22, 32'h11};
        bus.cl_req_fcn  = 2'b00;
        bus.cl_req_typ  = {MT_B, MT_WD};

        tbl[0]  = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b01, 1'b1, 32'h100, 2'b00};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b10, 1'b1, 32'h200, 2'b00};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b01, 1'b1, 32'h100, 2'b00};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b10, 1'b1, 32'h200, 2'b00};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b00, 1'b0, 32'h100, 2'b00};
        tbl[5]  = '{2'b11, 1'b1, 1'b1, 32'hA0, 2'b00, 1'b0, 32'h100, 2'b01};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b01, 1'b1, 32'h100, 2'b00};
        tbl[7]  = '{2'b00, 1'b1, 1'b1, 32'hA1, 2'b00, 1'b0, 32'h0,   2'b10};
        tbl[8]  = '{2'b10, 1'b1, 1'b1, 32'hA2, 2'b10, 1'b1, 32'h200, 2'b01};
        tbl[9]  = '{2'b00, 1'b1, 1'b1, 32'hA3, 2'b00, 1'b0, 32'h0,   2'b10};
        tbl[10] = '{2'b00, 1'b1, 1'b1, 32'hA4, 2'b00, 1'b0, 32'h0,   2'b01};
        tbl[11] = '{2'b00, 1'b1, 1'b1, 32'hA5, 2'b00, 1'b0, 32'h0,   2'b10};
        tbl[12] = '{2'b01, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 32'h100, 2'b00};
        tbl[13] = '{2'b10, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 32'h200, 2'b00};
        tbl[14] = '{2'b00, 1'b1, 1'b0, 32'h0,  2'b00, 1'b0, 32'h0,   2'b00};

        // Reset state
        #1;
        chk("rst_mval", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_crdy", 64'(bus.cl_req_ready), 64'd0);
        chk("rst_crv", 64'(bus.cl_resp_valid), 64'd0);
        chk("rst_err", 64'(err_orphan), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single client load, response after 3 cycles
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        #1;
        chk("sc_crdy", 64'(bus.cl_req_ready), 64'd1);
        chk("sc_addr", 64'(bus.mem_req_addr), 64'h100);
        chk("sc_fcn", 64'(bus.mem_req_fcn), 64'(M_XRD));
        chk("sc_typ", 64'(bus.mem_req_typ), 64'(MT_WD));
        chk("sc_wdata", 64'(bus.mem_req_data), 64'h11);
        tick();
        drive(2'b00, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("sc_wait_crv", 64'(bus.cl_resp_valid), 64'd0);
            tick();
        end
        drive(2'b00, 1'b1, 1'b1, 32'hDEADBEEF);
        #1;
        chk("sc_crv", 64'(bus.cl_resp_valid), 64'd1);
        chk("sc_rdata", 64'(bus.cl_resp_data), 64'hDEADBEEF);
        tick();
        drive(2'b00, 1'b1, 1'b0, 32'h0);
        #1;
        chk("sc_crv_once", 64'(bus.cl_resp_valid), 64'd0);

        // Interleaved routing 1,0,1 with data = address
        bus.cl_req_fcn = 2'b10;
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        #1;
        chk("il_fcn", 64'(bus.mem_req_fcn), 64'(M_XWR));
        chk("il_typ", 64'(bus.mem_req_typ), 64'(MT_B));
        chk("il_crdy0", 64'(bus.cl_req_ready), 64'd2);
        tick();
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        #1;
        chk("il_crdy1", 64'(bus.cl_req_ready), 64'd1);
        tick();
        bus.cl_req_addr = {32'h204, 32'h100};
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        #1;
        chk("il_crdy2", 64'(bus.cl_req_ready), 64'd2);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'h200);
        #1;
        chk("il_r0", 64'(bus.cl_resp_valid), 64'd2);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'h100);
        #1;
        chk("il_r1", 64'(bus.cl_resp_valid), 64'd1);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'h204);
        #1;
        chk("il_r2", 64'(bus.cl_resp_valid), 64'd2);
        chk("il_d2", 64'(bus.cl_resp_data), 64'h204);
        tick();
        bus.cl_req_addr = {32'h200, 32'h100};
        bus.cl_req_fcn  = 2'b00;

        // Vector table: fill, full stall, refill, push+pop, drain, no-ready
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].mrdy, tbl[i].rv, tbl[i].rdata);
            #1;
            chk($sformatf("t%0d_crdy", i), 64'(bus.cl_req_ready),
                64'(tbl[i].crdy));
            chk($sformatf("t%0d_mval", i), 64'(bus.mem_req_valid),
                64'(tbl[i].mval));
            chk($sformatf("t%0d_crv", i), 64'(bus.cl_resp_valid),
                64'(tbl[i].crv));
            if (tbl[i].v != 2'b00)
                chk($sformatf("t%0d_addr", i), 64'(bus.mem_req_addr),
                    64'(tbl[i].addr));
            if (tbl[i].crv != 2'b00)
                chk($sformatf("t%0d_rdata", i), 64'(bus.cl_resp_data),
                    64'(tbl[i].rdata));
            tick();
        end
        chk("t_err", 64'(err_orphan), 64'd0);

        // Fairness with one response per cycle
        gcnt[0] = 0;
        gcnt[1] = 0;
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 1'b1, (i > 0), 32'(i));
            #1;
            chk($sformatf("fair%0d_crdy", i), 64'(bus.cl_req_ready),
                (i % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("fair%0d_crv", i), 64'(bus.cl_resp_valid),
                (i == 0) ? 64'd0 : ((i % 2 == 1) ? 64'd1 : 64'd2));
            if (bus.cl_req_ready[0]) gcnt[0]++;
            if (bus.cl_req_ready[1]) gcnt[1]++;
            tick();
        end
        chk("fair_cnt0", 64'(gcnt[0]), 64'd4);
        chk("fair_cnt1", 64'(gcnt[1]), 64'd4);
        drive(2'b00, 1'b1, 1'b1, 32'h0);
        #1;
        chk("fair_last", 64'(bus.cl_resp_valid), 64'd2);
        tick();

        // Reset with two requests outstanding
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        tick();
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'h55);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_crv", 64'(bus.cl_resp_valid), 64'd0);
        chk("mr_crdy", 64'(bus.cl_req_ready), 64'd0);
        chk("mr_err", 64'(err_orphan), 64'd0);
`ifdef MEM_ARB_PERF_EN
        chk("mr_perf", perf_grant_cnt, 64'd0);
`endif
        tick();
        rst = 1'b1;
        drive(2'b01, 1'b1, 1'b1, 32'h66);
        #1;
        chk("orph_crv", 64'(bus.cl_resp_valid), 64'd0);
        chk("first_crdy", 64'(bus.cl_req_ready), 64'd1);
        chk("first_mval", 64'(bus.mem_req_valid), 64'd1);
        tick();
        drive(2'b00, 1'b1, 1'b0, 32'h0);
        #1;
        chk("orph_err", 64'(err_orphan), 64'd1);
`ifdef MEM_ARB_PERF_EN
        chk("perf_c0", 64'(perf_grant_cnt[31:0]), 64'd1);
        chk("perf_c1", 64'(perf_grant_cnt[63:32]), 64'd0);
`endif
        tick();
        #1;
        chk("orph_sticky", 64'(err_orphan), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
